// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes from issue to writeback.
// It tells decode whether rs1/rs2 can be served by the forwarding network
// or must stall.
// Optional build macro SCOREBOARD_STATS_EN adds two registered stall statistics counters.
//
// Handshake: an issue is accepted on a rising edge only when all of these hold:
// issue_valid=1, issue_ready=1, stall=0, flush=0, issue_dst!=0.
// issue_ready depends only on issue_dst and state, never on issue_valid.
module hazard_scoreboard #(
    parameter int NREG         = 32,
    parameter int CNT_W        = 2,
    parameter int LOAD_FWD_AGE = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_dst,
    input  logic [1:0]      issue_kind,
    input  logic            wb_valid,
    input  logic [4:0]      wb_dst,
    input  logic            flush,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic            issue_ready,
    output logic [NREG-1:0] busy_mask
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     load_use_stalls
`endif
);

    localparam logic [1:0] KIND_LOAD      = 2'd1;
    localparam int         LOAD_BLOCK_AGE = LOAD_FWD_AGE - 1;

    // Per-register state.
    // Entry 0 is never written, so x0 always reads as idle.
    logic [CNT_W-1:0] cnt  [NREG];
    logic [1:0]       kind [NREG];
    logic [1:0]       age  [NREG];

    logic            issue_fire;
    logic            wb_fire;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            blk1, blk2;
    logic            lblk1, lblk2;

    // A source is blocked in two cases.
    // Case 1: its youngest producer is a load that is still too young to forward.
    // Case 2: its youngest producer is a multi-cycle op; kind values 2 and 3 both have bit 1 set.
    function automatic logic src_blocked(input logic [CNT_W-1:0] c,
                                         input logic [1:0]       k,
                                         input logic [1:0]       a);
        return (c != '0) &&
               (((k == KIND_LOAD) && (int'({30'd0, a}) < LOAD_BLOCK_AGE)) || k[1]);
    endfunction

    function automatic logic src_load_blocked(input logic [CNT_W-1:0] c,
                                              input logic [1:0]       k,
                                              input logic [1:0]       a);
        return (c != '0) && (k == KIND_LOAD) && (int'({30'd0, a}) < LOAD_BLOCK_AGE);
    endfunction

    // Hazard detection and issue gating, combinational from state and decode sources.
    always_comb begin
        blk1        = src_blocked(cnt[rs1], kind[rs1], age[rs1]);
        blk2        = src_blocked(cnt[rs2], kind[rs2], age[rs2]);
        lblk1       = src_load_blocked(cnt[rs1], kind[rs1], age[rs1]);
        lblk2       = src_load_blocked(cnt[rs2], kind[rs2], age[rs2]);
        stall       = blk1 | blk2;
        issue_ready = !((issue_dst != 5'd0) && (cnt[issue_dst] == '1));
        issue_fire  = issue_valid && !stall && issue_ready && (issue_dst != 5'd0);
        wb_fire     = wb_valid && (wb_dst != 5'd0) && (cnt[wb_dst] != '0);
        inc_vec     = '0;
        dec_vec     = '0;
        if (issue_fire) inc_vec[issue_dst] = 1'b1;
        if (wb_fire)    dec_vec[wb_dst]    = 1'b1;
        for (int i = 0; i < NREG; i++) busy_mask[i] = (cnt[i] != '0);
    end

    // Counter, kind and age update.
    // Reset or flush clears everything.
    // An issue and a writeback to the same register cancel in the counter.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i]  <= '0;
                kind[i] <= 2'd0;
                age[i]  <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
                if (inc_vec[i]) begin
                    kind[i] <= issue_kind;
                    age[i]  <= 2'd0;
                end else if ((cnt[i] != '0) && (age[i] != 2'd3)) begin
                    age[i]  <= age[i] + 2'd1;
                end
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    // Stall statistics.
    // These counters survive a flush and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles    <= 32'd0;
            load_use_stalls <= 32'd0;
        end else begin
            if (stall)           stall_cycles    <= stall_cycles + 32'd1;
            if (lblk1 || lblk2)  load_use_stalls <= load_use_stalls + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = lblk1 ^ lblk2;
`endif

endmodule
